// File: rtl/dotprod_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dotprod_ctrl_pkg
//  Description : Shared types and default sizes for the dot-product sequencer
//                and its RAM-port multiplexer.
//  Revision    : 1.0 - initial release
// ============================================================================
package dotprod_ctrl_pkg;

    // Default geometry of the operand RAMs and result path
    localparam int unsigned DEF_ADDR_W      = 16;
    localparam int unsigned DEF_DATA_W      = 32;

    // Default watchdog limit and counter width (counter must hold the limit)
    localparam int unsigned DEF_TIMEOUT_CYC = 1048576;
    localparam int unsigned DEF_TO_W        = 21;

    // Width of the job-length field on the command and engine interfaces
    localparam int unsigned CMD_N_W         = 32;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_HOLD  = 3'd4
    } ctrl_state_t;

    // Which agent drives a RAM port
    typedef enum logic [1:0] {
        PORT_IDLE = 2'd0,
        PORT_LOAD = 2'd1,
        PORT_ENG  = 2'd2
    } port_sel_t;

endpackage
`default_nettype wire

// File: rtl/dotprod_ram_port_mux.sv
`default_nettype none
// ============================================================================
//  Module      : dotprod_ram_port_mux
//  Description : Combinational owner select for one operand RAM port. Drives
//                the host load path, the engine path, or a quiet (all-zero)
//                port.
//  Revision    : 1.0 - initial release
// ============================================================================
module dotprod_ram_port_mux
    import dotprod_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  port_sel_t           i_sel,
    input  logic                i_ld_we,
    input  logic [ADDR_W-1:0]   i_ld_addr,
    input  logic [DATA_W-1:0]   i_ld_din,
    input  logic                i_eng_rd_en,
    input  logic [ADDR_W-1:0]   i_eng_addr,
    input  logic [DATA_W-1:0]   i_eng_din,
    output logic                o_ram_we,
    output logic [ADDR_W-1:0]   o_ram_addr,
    output logic [DATA_W-1:0]   o_ram_din
);

    // Route the selected agent onto the RAM port; the engine writes whenever it is not reading
    always_comb begin
        o_ram_we   = 1'b0;
        o_ram_addr = '0;
        o_ram_din  = '0;
        case (i_sel)
            PORT_LOAD: begin
                o_ram_we   = i_ld_we;
                o_ram_addr = i_ld_addr;
                o_ram_din  = i_ld_din;
            end
            PORT_ENG: begin
                o_ram_we   = !i_eng_rd_en;
                o_ram_addr = i_eng_addr;
                o_ram_din  = i_eng_din;
            end
            default: begin
                o_ram_we   = 1'b0;
                o_ram_addr = '0;
                o_ram_din  = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dotprod_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dotprod_seq_ctrl
//  Description : Job sequencer and RAM-port arbiter for the dot-product
//                engine. Loads n operand pairs into RAM A/B, hands both ports
//                to the engine, waits for completion under a watchdog, and
//                returns the result on a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module dotprod_seq_ctrl
    import dotprod_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned DEPTH       = 1 << ADDR_W,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int unsigned TO_W        = DEF_TO_W
) (
    input  logic                clk,
    input  logic                rst,
    // job command
    input  logic                cmd_start,
    input  logic [CMD_N_W-1:0]  cmd_n,
    output logic                busy,
    // host operand loader
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [DATA_W-1:0]   ld_a,
    input  logic [DATA_W-1:0]   ld_b,
    // operand RAM ports
    output logic                ram_a_we,
    output logic                ram_b_we,
    output logic [ADDR_W-1:0]   ram_a_addr,
    output logic [ADDR_W-1:0]   ram_b_addr,
    output logic [DATA_W-1:0]   ram_a_din,
    output logic [DATA_W-1:0]   ram_b_din,
    // engine control and RAM access
    output logic                eng_start,
    output logic [CMD_N_W-1:0]  eng_n,
    input  logic                eng_a_rd_en,
    input  logic                eng_b_rd_en,
    input  logic [ADDR_W-1:0]   eng_a_addr,
    input  logic [ADDR_W-1:0]   eng_b_addr,
    input  logic [DATA_W-1:0]   eng_a_out,
    input  logic [DATA_W-1:0]   eng_b_out,
    input  logic                eng_done,
    input  logic [DATA_W-1:0]   eng_result,
    // result handshake and errors
    output logic                res_valid,
    input  logic                res_ready,
    output logic [DATA_W-1:0]   res_data,
    output logic                err_len,
    output logic                err_timeout
);

    localparam logic [TO_W-1:0] c_WD_LAST = TO_W'(TIMEOUT_CYC - 1);

    ctrl_state_t          r_state;
    logic [ADDR_W-1:0]    r_addr;
    logic [CMD_N_W-1:0]   r_n_q;
    logic [TO_W-1:0]      r_wd;
    logic                 r_busy;
    logic                 r_ld_ready;
    logic                 r_eng_start;
    logic [CMD_N_W-1:0]   r_eng_n;
    logic                 r_res_valid;
    logic [DATA_W-1:0]    r_res_data;
    logic                 r_err_len;
    logic                 r_err_timeout;

    logic                 w_beat;
    logic                 w_last_beat;
    port_sel_t            w_port_sel;

    // A beat is a taken operand pair; the final one lands on address n_q-1
    assign w_beat      = (r_state == ST_LOAD) && r_ld_ready && ld_valid;
    assign w_last_beat = (CMD_N_W'(r_addr) == (r_n_q - CMD_N_W'(1)));

    // Port ownership follows the state; reset forces the ports quiet so no write leaks out
    always_comb begin
        w_port_sel = PORT_IDLE;
        if (!rst) begin
            case (r_state)
                ST_LOAD: w_port_sel = PORT_LOAD;
                ST_RUN:  w_port_sel = PORT_ENG;
                default: w_port_sel = PORT_IDLE;
            endcase
        end
    end

    // Sequencer: command decode, load addressing, engine launch, watchdog, result hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_n_q         <= '0;
            r_wd          <= '0;
            r_busy        <= 1'b0;
            r_ld_ready    <= 1'b0;
            r_eng_start   <= 1'b0;
            r_eng_n       <= '0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_err_len     <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_eng_start   <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_start) begin
                        if (cmd_n == '0) begin
                            // empty job: answer zero without touching the engine
                            r_res_data  <= '0;
                            r_res_valid <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= ST_HOLD;
                        end else if (cmd_n > DEPTH) begin
                            r_err_len   <= 1'b1;
                        end else begin
                            r_n_q       <= cmd_n;
                            r_addr      <= '0;
                            r_ld_ready  <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_beat) begin
                        // wraps to 0 after a full-depth load
                        r_addr <= r_addr + ADDR_W'(1);
                        if (w_last_beat) begin
                            r_ld_ready  <= 1'b0;
                            r_eng_start <= 1'b1;
                            r_eng_n     <= r_n_q;
                            r_state     <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    r_wd    <= '0;
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    // completion takes priority over a simultaneous watchdog expiry
                    if (eng_done) begin
                        r_res_data  <= eng_result;
                        r_res_valid <= 1'b1;
                        r_eng_n     <= '0;
                        r_state     <= ST_HOLD;
                    end else if (r_wd == c_WD_LAST) begin
                        r_err_timeout <= 1'b1;
                        r_busy        <= 1'b0;
                        r_eng_n       <= '0;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_wd <= r_wd + TO_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_ld_ready  <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_eng_n     <= '0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign ld_ready    = r_ld_ready;
    assign eng_start   = r_eng_start;
    assign eng_n       = r_eng_n;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign err_len     = r_err_len;
    assign err_timeout = r_err_timeout;

    dotprod_ram_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port_a (
        .i_sel       (w_port_sel),
        .i_ld_we     (w_beat),
        .i_ld_addr   (r_addr),
        .i_ld_din    (ld_a),
        .i_eng_rd_en (eng_a_rd_en),
        .i_eng_addr  (eng_a_addr),
        .i_eng_din   (eng_a_out),
        .o_ram_we    (ram_a_we),
        .o_ram_addr  (ram_a_addr),
        .o_ram_din   (ram_a_din)
    );

    dotprod_ram_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port_b (
        .i_sel       (w_port_sel),
        .i_ld_we     (w_beat),
        .i_ld_addr   (r_addr),
        .i_ld_din    (ld_b),
        .i_eng_rd_en (eng_b_rd_en),
        .i_eng_addr  (eng_b_addr),
        .i_eng_din   (eng_b_out),
        .o_ram_we    (ram_b_we),
        .o_ram_addr  (ram_b_addr),
        .o_ram_din   (ram_b_din)
    );

endmodule
`default_nettype wire

// File: tb/tb_dotprod_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dotprod_seq_ctrl
//  Description : Self-checking bench for dotprod_seq_ctrl with small RAMs
//                (16 words) and a 100-cycle watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dotprod_seq_ctrl;

    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int DEP = 16;
    localparam int TOC = 100;
    localparam int TOW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_start;
    logic [31:0]   cmd_n;
    logic          busy;
    logic          ld_valid, ld_ready;
    logic [DW-1:0] ld_a, ld_b;
    logic          ram_a_we, ram_b_we;
    logic [AW-1:0] ram_a_addr, ram_b_addr;
    logic [DW-1:0] ram_a_din, ram_b_din;
    logic          eng_start;
    logic [31:0]   eng_n;
    logic          eng_a_rd_en, eng_b_rd_en;
    logic [AW-1:0] eng_a_addr, eng_b_addr;
    logic [DW-1:0] eng_a_out, eng_b_out;
    logic          eng_done;
    logic [DW-1:0] eng_result;
    logic          res_valid, res_ready;
    logic [DW-1:0] res_data;
    logic          err_len, err_timeout;

    always #5 clk = ~clk;

    dotprod_seq_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TOC), .TO_W(TOW)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_start(cmd_start), .cmd_n(cmd_n), .busy(busy),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_a(ld_a), .ld_b(ld_b),
        .ram_a_we(ram_a_we), .ram_b_we(ram_b_we),
        .ram_a_addr(ram_a_addr), .ram_b_addr(ram_b_addr),
        .ram_a_din(ram_a_din), .ram_b_din(ram_b_din),
        .eng_start(eng_start), .eng_n(eng_n),
        .eng_a_rd_en(eng_a_rd_en), .eng_b_rd_en(eng_b_rd_en),
        .eng_a_addr(eng_a_addr), .eng_b_addr(eng_b_addr),
        .eng_a_out(eng_a_out), .eng_b_out(eng_b_out),
        .eng_done(eng_done), .eng_result(eng_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .err_len(err_len), .err_timeout(err_timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // RAM contents as seen through the DUT ports
    logic [DW-1:0] mem_a [DEP];
    logic [DW-1:0] mem_b [DEP];

    // Operand vectors of the current job
    logic [DW-1:0] job_a [DEP];
    logic [DW-1:0] job_b [DEP];

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } wr_t;
    wr_t exp_q[$];

    // Expected phase of the job, maintained by the stimulus
    bit mon_en    = 1'b0;
    bit exp_busy  = 1'b0;
    bit exp_load  = 1'b0;
    bit eng_owns  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] model_dot(input int n);
        logic [DW-1:0] s;
        s = '0;
        for (int i = 0; i < n; i++) s = s + job_a[i] * job_b[i];
        return s;
    endfunction

    always @(posedge clk) begin
        if (ram_a_we) mem_a[ram_a_addr] <= ram_a_din;
        if (ram_b_we) mem_b[ram_b_addr] <= ram_b_din;
    end

    // Per-cycle compare of port ownership, load writes, busy and ld_ready
    always @(negedge clk) begin
        wr_t w;
        if (mon_en) begin
            if (rst) begin
                check("rst_no_write", {ram_a_we, ram_b_we}, 2'b00);
            end else begin
                check("busy", busy, exp_busy);
                check("ld_ready", ld_ready, exp_load);
                if (eng_owns) begin
                    check("eng_a_addr", ram_a_addr, eng_a_addr);
                    check("eng_b_addr", ram_b_addr, eng_b_addr);
                    check("eng_a_din", ram_a_din, eng_a_out);
                    check("eng_b_din", ram_b_din, eng_b_out);
                    check("eng_we", {ram_a_we, ram_b_we}, {!eng_a_rd_en, !eng_b_rd_en});
                end else if (exp_load) begin
                    check("ld_we", {ram_a_we, ram_b_we}, {ld_valid, ld_valid});
                    if (ld_valid) begin
                        if (exp_q.size() == 0) begin
                            check("ld_extra_write", 1, 0);
                        end else begin
                            w = exp_q.pop_front();
                            check("ld_a_addr", ram_a_addr, w.addr);
                            check("ld_b_addr", ram_b_addr, w.addr);
                            check("ld_a_din", ram_a_din, w.a);
                            check("ld_b_din", ram_b_din, w.b);
                        end
                    end
                end else begin
                    check("quiet_we_addr", {ram_a_we, ram_b_we, ram_a_addr, ram_b_addr}, '0);
                    check("quiet_din_a", ram_a_din, '0);
                    check("quiet_din_b", ram_b_din, '0);
                end
            end
        end
    end

    task automatic start_job(input int n);
        cmd_start = 1'b1;
        cmd_n     = 32'(n);
        step();
        cmd_start = 1'b0;
        exp_busy  = 1'b1;
        exp_load  = 1'b1;
        for (int i = 0; i < n; i++) exp_q.push_back('{AW'(i), job_a[i], job_b[i]});
    endtask

    task automatic load_beats(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 2 == 1)) begin
                ld_valid = 1'b0;
                ld_a     = 32'hDEAD_0000;
                ld_b     = 32'hDEAD_0001;
                step();
            end
            ld_valid = 1'b1;
            ld_a     = job_a[i];
            ld_b     = job_b[i];
            step();
        end
        // ld_valid stays high one more cycle: it must not produce a write
        exp_load = 1'b0;
        ld_a     = 32'hBAD0_0000;
        ld_b     = 32'hBAD0_0001;
        check("eng_start_pulse", eng_start, 1'b1);
        check("eng_n_start", eng_n, 32'(n));
    endtask

    task automatic enter_run(input int n);
        step();
        ld_valid = 1'b0;
        eng_owns = 1'b1;
        check("eng_start_one_cycle", eng_start, 1'b0);
        check("eng_n_run", eng_n, 32'(n));
    endtask

    task automatic run_engine(input int n);
        logic [DW-1:0] acc;
        acc = '0;
        for (int i = 0; i < n; i++) begin
            eng_a_rd_en = 1'b1;
            eng_b_rd_en = 1'b1;
            eng_a_addr  = AW'(i);
            eng_b_addr  = AW'(i);
            eng_a_out   = 32'h1000 + 32'(i);
            eng_b_out   = 32'h2000 + 32'(i);
            #1;
            acc = acc + mem_a[ram_a_addr] * mem_b[ram_b_addr];
            step();
        end
        eng_a_rd_en = 1'b0;
        eng_a_addr  = AW'(DEP - 1);
        eng_a_out   = 32'hC0DE_0000 + 32'(n);
        step();
        eng_a_rd_en = 1'b1;
        eng_b_rd_en = 1'b0;
        eng_b_addr  = AW'(DEP - 2);
        eng_b_out   = 32'hBEEF_0000 + 32'(n);
        step();
        eng_b_rd_en = 1'b1;
        eng_a_out   = '0;
        eng_b_out   = '0;
        eng_done    = 1'b1;
        eng_result  = acc;
        step();
        eng_done = 1'b0;
        eng_owns = 1'b0;
    endtask

    task automatic release_hold();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        exp_busy  = 1'b0;
        check("res_valid_drop", res_valid, 1'b0);
    endtask

    task automatic full_job(input int n, input bit gaps, input int hold_cyc, input logic [DW-1:0] lit);
        start_job(n);
        load_beats(n, gaps);
        enter_run(n);
        run_engine(n);
        check("res_valid", res_valid, 1'b1);
        check("res_data_model", res_data, model_dot(n));
        check("res_data_lit", res_data, lit);
        check("writes_all_seen", exp_q.size(), 0);
        for (int h = 0; h < hold_cyc; h++) begin
            cmd_start = (h == 2);
            cmd_n     = 32'd2;
            step();
            check("hold_valid", res_valid, 1'b1);
            check("hold_data", res_data, lit);
        end
        cmd_start = 1'b0;
        release_hold();
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int cyc;
        rst = 1'b1; cmd_start = 1'b0; cmd_n = '0;
        ld_valid = 1'b0; ld_a = '0; ld_b = '0;
        eng_a_rd_en = 1'b1; eng_b_rd_en = 1'b1;
        eng_a_addr = '0; eng_b_addr = '0; eng_a_out = '0; eng_b_out = '0;
        eng_done = 1'b0; eng_result = '0; res_ready = 1'b0;
        for (int i = 0; i < DEP; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
        step();
        mon_en = 1'b1;
        step(); step();
        rst = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_eng_start", eng_start, 1'b0);
        check("rst_res_data", res_data, '0);
        check("rst_errs", {err_len, err_timeout}, 2'b00);
        step();

        // n=4 basic job: 1*5+2*6+3*7+4*8 = 70
        for (int i = 0; i < 4; i++) begin job_a[i] = 32'(i + 1); job_b[i] = 32'(i + 5); end
        full_job(4, 1'b0, 0, 32'd70);

        // empty job: result 0 straight away, engine untouched, late eng_done ignored
        cmd_start = 1'b1; cmd_n = 32'd0;
        step();
        cmd_start = 1'b0; exp_busy = 1'b1;
        check("zero_res_valid", res_valid, 1'b1);
        check("zero_res_data", res_data, '0);
        check("zero_eng_start", eng_start, 1'b0);
        eng_done = 1'b1; eng_result = 32'd99;
        step();
        eng_done = 1'b0;
        check("zero_done_ignored", res_data, '0);
        check("zero_eng_start2", eng_start, 1'b0);
        release_hold();

        // oversize job rejected, then a valid n=1 job: 9*9 = 81
        cmd_start = 1'b1; cmd_n = 32'(DEP + 1);
        step();
        cmd_start = 1'b0;
        check("err_len_pulse", err_len, 1'b1);
        step();
        check("err_len_one_cycle", err_len, 1'b0);
        job_a[0] = 32'd9; job_b[0] = 32'd9;
        full_job(1, 1'b0, 0, 32'd81);

        // gapped load, 10 cycles back-pressure, cmd_start in HOLD: 20+60+120 = 200
        job_a[0] = 32'd2; job_a[1] = 32'd3; job_a[2] = 32'd4;
        job_b[0] = 32'd10; job_b[1] = 32'd20; job_b[2] = 32'd30;
        full_job(3, 1'b1, 10, 32'd200);

        // full-depth load, address wraps with no extra write: 2*(1+..+16) = 272
        for (int i = 0; i < DEP; i++) begin job_a[i] = 32'(i + 1); job_b[i] = 32'd2; end
        full_job(DEP, 1'b0, 0, 32'd272);

        // watchdog expiry: engine never finishes
        job_a[0] = 32'd1; job_a[1] = 32'd1; job_b[0] = 32'd1; job_b[1] = 32'd1;
        start_job(2);
        load_beats(2, 1'b0);
        enter_run(2);
        cyc = 0;
        while (err_timeout !== 1'b1 && cyc < 2 * TOC) begin
            step();
            cyc++;
            if (err_timeout === 1'b1) begin eng_owns = 1'b0; exp_busy = 1'b0; end
        end
        check("timeout_cycles", cyc, TOC);
        check("timeout_no_valid", res_valid, 1'b0);
        step();
        check("timeout_one_cycle", err_timeout, 1'b0);
        check("timeout_no_valid2", res_valid, 1'b0);

        // done arrives in the expiry cycle: result wins
        start_job(2);
        load_beats(2, 1'b0);
        enter_run(2);
        for (int i = 1; i < TOC; i++) step();
        eng_done = 1'b1; eng_result = 32'h1234_5678;
        step();
        eng_done = 1'b0; eng_owns = 1'b0;
        check("race_res_valid", res_valid, 1'b1);
        check("race_res_data", res_data, 32'h1234_5678);
        check("race_no_timeout", err_timeout, 1'b0);
        release_hold();
        check("race_no_timeout2", err_timeout, 1'b0);

        // reset after two load beats, then n=3 job: 7+8+18 = 33
        for (int i = 0; i < 5; i++) begin job_a[i] = 32'(50 + i); job_b[i] = 32'(60 + i); end
        start_job(5);
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1; ld_a = job_a[i]; ld_b = job_b[i];
            step();
        end
        rst = 1'b1;
        ld_a = job_a[2]; ld_b = job_b[2];
        step();
        rst = 1'b0; ld_valid = 1'b0;
        exp_load = 1'b0; exp_busy = 1'b0;
        exp_q.delete();
        check("rstmid_busy_ready", {busy, ld_ready}, 2'b00);
        check("rstmid_we", {ram_a_we, ram_b_we}, 2'b00);
        check("rstmid_eng", {eng_start, eng_n}, '0);
        check("rstmid_res", {res_valid, err_len, err_timeout}, 3'b000);
        check("rstmid_res_data", res_data, '0);
        step();
        job_a[0] = 32'd7; job_a[1] = 32'd8; job_a[2] = 32'd9;
        job_b[0] = 32'd1; job_b[1] = 32'd1; job_b[2] = 32'd2;
        full_job(3, 1'b0, 0, 32'd33);

        step(); step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dotprod_seq_ctrl.md
Name: dotprod_seq_ctrl

Overview:
Sequencer and RAM-port arbiter for the dot-product engine and its two operand block RAMs (A, B). It accepts a job command with length n and streams n operand pairs from a host loader into RAM A/B at addresses 0..n-1. It then grants both RAM ports to the engine, issues the engine start, and waits for done. The captured result is returned on a valid/ready handshake with a watchdog timeout. It replaces ad-hoc init/start muxing at top level with one owned FSM.

Parameters:
ADDR_W, 16, RAM address width
DATA_W, 32, operand/result width
DEPTH, 2**ADDR_W, max legal n (RAM words)
TIMEOUT_CYC, 1048576, max RUN cycles before abort
TO_W, 21, watchdog counter width (must hold TIMEOUT_CYC)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_start  in  1  job request pulse, sampled only in IDLE
cmd_n  in  32  job length, sampled with cmd_start
busy  out  1  high in every state except IDLE
ld_valid / ld_ready  in / out  1 / 1  host operand-pair handshake
ld_a, ld_b  in  DATA_W  operand pair for current load address
ram_a_we, ram_b_we  out  1  RAM write enables
ram_a_addr, ram_b_addr  out  ADDR_W  RAM addresses
ram_a_din, ram_b_din  out  DATA_W  RAM write data
eng_start  out  1  one-cycle engine start
eng_n  out  32  job length to engine, stable from START through RUN
eng_a_rd_en, eng_b_rd_en  in  1  engine read strobes; engine write = !rd_en
eng_a_addr, eng_b_addr  in  ADDR_W  engine RAM addresses
eng_a_out, eng_b_out  in  DATA_W  engine write data
eng_done  in  1  engine completion
eng_result  in  DATA_W  engine result, valid with eng_done
res_valid / res_ready  out / in  1 / 1  result handshake
res_data  out  DATA_W  captured result
err_len  out  1  one-cycle pulse: cmd_n > DEPTH
err_timeout  out  1  one-cycle pulse: watchdog expiry

Behaviour:
- Reset values: all outputs 0, state IDLE, internal load addr 0, n_q 0, watchdog 0. Reset in any state aborts the job. No RAM write in the reset cycle.
- IDLE: cmd_start with 1 <= cmd_n <= DEPTH: n_q = cmd_n, addr = 0, go to LOAD next cycle.
  - cmd_n == 0: res_data = 0, go to HOLD. Engine is never started.
  - cmd_n > DEPTH: err_len pulses next cycle, stay IDLE.
- LOAD: ld_ready = 1. Each beat (ld_valid & ld_ready) writes ld_a->A[addr] and ld_b->B[addr] in the same cycle: we = 1, addr = load addr, din = ld data. Then addr++.
  - Beat with addr == n_q-1 -> START. ld_ready is 0 in all other states.
- START: eng_start = 1 for exactly one cycle, eng_n = n_q. Clear watchdog, go to RUN. Latency: last load beat at cycle k -> eng_start at k+1.
- RUN: RAM ports are combinationally muxed to the engine.
  - ram_x_addr = eng_x_addr, ram_x_din = eng_x_out, ram_x_we = !eng_x_rd_en.
  - Watchdog increments each cycle.
  - eng_done: res_data <= eng_result, go to HOLD. res_valid is high the cycle after eng_done.
  - Watchdog == TIMEOUT_CYC-1 without done: err_timeout pulses, go to IDLE, res_valid never asserted.
  - eng_done and expiry in the same cycle: done wins.
- HOLD: res_valid = 1, res_data stable. res_ready -> IDLE next cycle. Back-pressure may last indefinitely.
- Outside LOAD/RUN: ram_*_we = 0, addr = 0, din = 0.
- Ignored inputs: cmd_start outside IDLE, eng_done outside RUN, ld_valid outside LOAD.
- Load address arithmetic is ADDR_W wide. n_q == DEPTH ends with addr wrapping to 0, with no extra write.

Decomposition:
- Package dotprod_ctrl_pkg: state enum (IDLE, LOAD, START, RUN, HOLD), ADDR_W/DATA_W defaults, TIMEOUT_CYC default.
- One combinational sub-module, dotprod_ram_port_mux: selects load / engine / idle drive for one RAM. Instantiated twice (A, B).

Test Plan:
- n=4, load A={1,2,3,4}, B={5,6,7,8}, behavioural engine -> RAM writes at addr 0..3, eng_start 1 cycle after 4th beat, eng_n=4, res_data=70, res_valid the cycle after eng_done.
- cmd_n=0 -> res_valid=1 with res_data=0 on the next cycle; eng_start and all RAM writes stay 0.
- cmd_n=DEPTH+1 -> err_len one-cycle pulse, busy stays 0, a following valid command is accepted.
- TIMEOUT_CYC=100, engine never asserts done -> err_timeout pulse after 100 RUN cycles, return to IDLE, no res_valid. Separately, done and expiry in the same cycle -> result captured.
- Load with ld_valid gaps plus res_ready held low 10 cycles -> writes only on beats, addresses contiguous. res_data stable through HOLD, and a cmd_start during HOLD is ignored.
- rst asserted in LOAD after 2 beats -> all outputs 0 next cycle. A new n=3 job loads from addr 0 and completes correctly.
